mmio_timer_bank: RTL and testbench
==================================

MMIO_TIMER_BANK -- requirements
Module: mmio_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, counter/compare width (8..32).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0115, first register address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port vproc_mem_req_o  input  1  bus request.
REQ-007 SHALL have port vproc_mem_addr_o  input  32  register address, one register per address.
REQ-008 SHALL have port vproc_mem_we_o  input  1  1 = write, 0 = read.
REQ-009 SHALL have port vproc_mem_be_o  input  4  byte enables for writes.
REQ-010 SHALL have port vproc_mem_wdata_o  input  32  write data.
REQ-011 SHALL have port vproc_mem_rvalid_i  output  1  response valid.
REQ-012 SHALL have port vproc_mem_err_i  output  1  error, qualified by rvalid.
REQ-013 SHALL have port vproc_mem_rdata_i  output  32  read data.
REQ-014 SHALL have port timer_irq  output  NUM_TIMERS  per-channel level interrupt.

Function
REQ-015 Register map SHALL be: channel c, register r (0=CTRL, 1=CMP, 2=COUNT, 3=STATUS) at BASE_ADDR + 4*c + r.
REQ-016 CTRL SHALL hold: bit0 enable, bit1 periodic, bit2 irq_en, bits[15:8] prescale PSC; other bits read 0.
REQ-017 Every request SHALL get exactly one response: rvalid high for one cycle on the cycle after req is sampled; no back-pressure.
REQ-018 err SHALL be 1 with rvalid for an address outside the map or a write to COUNT; rdata SHALL be 0 on err; no state SHALL change.
REQ-019 Writes SHALL update only bytes with be set; be = 0 SHALL be a no-op write that still returns rvalid without err.
REQ-020 Writing CMP SHALL reset COUNT and the prescale counter to 0 and clear STATUS.expired; CMP values wider than CNT_W SHALL be truncated.
REQ-021 While enable = 1 and CMP != 0, the prescale counter SHALL count 0..PSC; COUNT SHALL increment by 1 on the cycle it wraps (one tick every PSC+1 cycles).
REQ-022 When a tick would make COUNT equal CMP, STATUS.expired SHALL be set the same cycle.
REQ-023 On expiry, one-shot mode (periodic = 0) SHALL clear enable and hold COUNT = CMP; periodic mode SHALL reload COUNT to 0 and continue.
REQ-024 CMP = 0 SHALL never expire; COUNT SHALL hold 0.
REQ-025 STATUS bit0 SHALL read expired; writing 1 to bit0 SHALL clear it (W1C), writing 0 SHALL have no effect.
REQ-026 If expiry and a W1C clear occur in the same cycle, set SHALL win; if expiry and a CMP write coincide, the CMP write SHALL win.
REQ-027 Clearing enable SHALL freeze COUNT and the prescale counter; re-enabling SHALL resume from the frozen values.
REQ-028 timer_irq[c] SHALL be registered: expired[c] & irq_en[c], visible one cycle after either changes.
REQ-029 Reads SHALL return the register value sampled in the request cycle, zero-extended to 32 bits.

Reset
REQ-030 While rst = 1, CTRL, CMP, COUNT, STATUS, prescale counters, rvalid, err, rdata and timer_irq SHALL all be 0.
REQ-031 Reset asserted mid-count or mid-transaction SHALL abort it with no response; the first request after deassertion SHALL be serviced normally.

Structure
REQ-032 Register offset enum, CTRL bit positions, PSC field range and a channel control struct typedef SHALL live in package timer_bank_pkg.
REQ-033 Per-channel counting SHALL be one sub-module, timer_channel, instantiated NUM_TIMERS times; decode and response logic SHALL be in the top.

Verification
REQ-034 Write CMP = 10, CTRL = 0x1 on ch0 -> expired reads 0 through cycle 9 after enable and 1 from tick 10; COUNT holds 10; enable reads 0.
REQ-035 On ch1, CTRL = 0x0703 (periodic, PSC = 7), CMP = 3 -> expiry every 24 cycles; after W1C of STATUS = 1, expired is set again 24 cycles later.
REQ-036 On ch2, CTRL = 0x5, CMP = 5 -> timer_irq[2] rises one cycle after expired; W1C drops it one cycle later; timer_irq for other channels stays 0.
REQ-037 Write to COUNT (BASE+2) and read of BASE + 4*NUM_TIMERS -> rvalid = 1, err = 1, rdata = 0; registers unchanged.
REQ-038 W1C issued in the same cycle as expiry -> expired remains 1; CMP write in the same cycle as expiry -> expired = 0, COUNT = 0.
REQ-039 Assert rst mid-count with CMP = 50 -> all registers and timer_irq read 0 after release; a following read of CTRL returns rvalid with 0.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared register map, control layout and helpers for the
// MMIO timer bank.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_CMP    = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_off_e;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PER_BIT = 1;
  localparam int CTRL_IRQ_BIT = 2;
  localparam int PSC_LSB      = 8;
  localparam int PSC_MSB      = 15;
  localparam int PSC_W        = PSC_MSB - PSC_LSB + 1;

  typedef struct packed {
    logic [PSC_W-1:0] psc;
    logic             irq_en;
    logic             periodic;
    logic             enable;
  } ctrl_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] w;
    w                   = '0;
    w[CTRL_EN_BIT]      = c.enable;
    w[CTRL_PER_BIT]     = c.periodic;
    w[CTRL_IRQ_BIT]     = c.irq_en;
    w[PSC_MSB:PSC_LSB]  = c.psc;
    return w;
  endfunction

  function automatic ctrl_t ctrl_unpack(input logic [31:0] w);
    ctrl_t c;
    c.enable   = w[CTRL_EN_BIT];
    c.periodic = w[CTRL_PER_BIT];
    c.irq_en   = w[CTRL_IRQ_BIT];
    c.psc      = w[PSC_MSB:PSC_LSB];
    return c;
  endfunction

endpackage

// File: rtl/mmio_timer_bank_channel.sv
// One timer channel: prescaler, counter, compare and expiry/irq
// state, with bus writes already decoded into strobes.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ctrl_we,
  input  ctrl_t            i_ctrl_wdata,
  input  logic             i_cmp_we,
  input  logic [CNT_W-1:0] i_cmp_wdata,
  input  logic             i_clr,
  output ctrl_t            o_ctrl,
  output logic [CNT_W-1:0] o_cmp,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expired,
  output logic             o_irq
);

  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cmp;
  logic [CNT_W-1:0] r_count;
  logic [PSC_W-1:0] r_psc;
  logic             r_exp;
  logic             r_irq;

  logic             w_active;
  logic             w_wrap;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_active  = r_ctrl.enable && (r_cmp != '0);
  // >= so a PSC lowered mid-count still wraps instead of running to 255
  assign w_wrap    = w_active && (r_psc >= r_ctrl.psc);
  assign w_cnt_inc = r_count + CNT_W'(1);
  assign w_hit     = w_wrap && (w_cnt_inc == r_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_cmp   <= '0;
      r_count <= '0;
      r_psc   <= '0;
      r_exp   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_exp & r_ctrl.irq_en;
      if (w_wrap) begin
        r_psc <= '0;
      end else if (w_active) begin
        r_psc <= r_psc + PSC_W'(1);
      end
      if (w_wrap) begin
        r_count <= (w_hit && r_ctrl.periodic) ? '0 : w_cnt_inc;
      end
      if (w_hit) begin
        r_exp <= 1'b1;
      end else if (i_clr) begin
        r_exp <= 1'b0;
      end
      if (w_hit && !r_ctrl.periodic) begin
        r_ctrl.enable <= 1'b0;
      end
      if (i_ctrl_we) begin
        r_ctrl <= i_ctrl_wdata;
      end
      if (i_cmp_we) begin
        r_cmp   <= i_cmp_wdata;
        r_count <= '0;
        r_psc   <= '0;
        r_exp   <= 1'b0;
      end
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_cmp     = r_cmp;
  assign o_count   = r_count;
  assign o_expired = r_exp;
  assign o_irq     = r_irq;

endmodule

// File: rtl/mmio_timer_bank.sv
// Bank of MMIO timers: address decode, byte-lane merge and the
// single-cycle response path around NUM_TIMERS channels.
module mmio_timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_TIMERS = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0115
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vproc_mem_req_o,
  input  logic [31:0]           vproc_mem_addr_o,
  input  logic                  vproc_mem_we_o,
  input  logic [3:0]            vproc_mem_be_o,
  input  logic [31:0]           vproc_mem_wdata_o,
  output logic                  vproc_mem_rvalid_i,
  output logic                  vproc_mem_err_i,
  output logic [31:0]           vproc_mem_rdata_i,
  output logic [NUM_TIMERS-1:0] timer_irq
);

  logic [31:0]           w_off;
  logic                  w_in_map;
  logic                  w_err;
  logic                  w_wr;
  reg_off_e              w_reg;
  logic [NUM_TIMERS-1:0] w_sel;
  logic [NUM_TIMERS-1:0] w_exp;
  ctrl_t                 w_ctrl [NUM_TIMERS];
  logic [CNT_W-1:0]      w_cmp  [NUM_TIMERS];
  logic [CNT_W-1:0]      w_cnt  [NUM_TIMERS];
  logic [31:0]           w_rd;

  logic                  r_rvalid;
  logic                  r_err;
  logic [31:0]           r_rdata;

  assign w_off    = vproc_mem_addr_o - BASE_ADDR;
  assign w_in_map = (vproc_mem_addr_o >= BASE_ADDR) &&
                    (w_off < 32'(4 * NUM_TIMERS));
  assign w_reg    = reg_off_e'(w_off[1:0]);
  assign w_err    = !w_in_map ||
                    (vproc_mem_we_o && (w_reg == REG_COUNT));
  assign w_wr     = vproc_mem_req_o && vproc_mem_we_o &&
                    !w_err && (|vproc_mem_be_o);

  for (genvar c = 0; c < NUM_TIMERS; c++) begin : g_ch
    logic             w_ctrl_we;
    logic             w_cmp_we;
    logic             w_clr;
    ctrl_t            w_ctrl_nx;
    logic [CNT_W-1:0] w_cmp_nx;

    assign w_sel[c]  = w_in_map && (w_off[31:2] == 30'(c));
    assign w_ctrl_we = w_wr && w_sel[c] && (w_reg == REG_CTRL);
    assign w_cmp_we  = w_wr && w_sel[c] && (w_reg == REG_CMP);
    assign w_clr     = w_wr && w_sel[c] && (w_reg == REG_STATUS) &&
                       vproc_mem_be_o[0] && vproc_mem_wdata_o[0];
    assign w_ctrl_nx = ctrl_unpack(be_merge(ctrl_pack(w_ctrl[c]),
                         vproc_mem_wdata_o, vproc_mem_be_o));
    assign w_cmp_nx  = CNT_W'(be_merge(32'(w_cmp[c]),
                         vproc_mem_wdata_o, vproc_mem_be_o));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_ctrl_we    (w_ctrl_we),
      .i_ctrl_wdata (w_ctrl_nx),
      .i_cmp_we     (w_cmp_we),
      .i_cmp_wdata  (w_cmp_nx),
      .i_clr        (w_clr),
      .o_ctrl       (w_ctrl[c]),
      .o_cmp        (w_cmp[c]),
      .o_count      (w_cnt[c]),
      .o_expired    (w_exp[c]),
      .o_irq        (timer_irq[c])
    );
  end

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NUM_TIMERS; c++) begin
      if (w_sel[c]) begin
        unique case (w_reg)
          REG_CTRL:   w_rd = ctrl_pack(w_ctrl[c]);
          REG_CMP:    w_rd = 32'(w_cmp[c]);
          REG_COUNT:  w_rd = 32'(w_cnt[c]);
          REG_STATUS: w_rd = {31'd0, w_exp[c]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= vproc_mem_req_o;
      r_err    <= vproc_mem_req_o && w_err;
      r_rdata  <= (vproc_mem_req_o && !w_err && !vproc_mem_we_o) ?
                  w_rd : '0;
    end
  end

  assign vproc_mem_rvalid_i = r_rvalid;
  assign vproc_mem_err_i    = r_err;
  assign vproc_mem_rdata_i  = r_rdata;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Randomized + directed bench for mmio_timer_bank with a
// behavioural model and a response scoreboard.
module tb_mmio_timer_bank;

  localparam int          NT   = 4;
  localparam logic [31:0] BASE = 32'h0000_0115;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          req   = 1'b0;
  logic          we    = 1'b0;
  logic [31:0]   addr  = '0;
  logic [3:0]    be    = '0;
  logic [31:0]   wdata = '0;
  logic          rvalid;
  logic          err;
  logic [31:0]   rdata;
  logic [NT-1:0] irq;

  int total = 0;
  int bad   = 0;

  mmio_timer_bank #(
    .NUM_TIMERS (NT),
    .CNT_W      (32),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .vproc_mem_req_o    (req),
    .vproc_mem_addr_o   (addr),
    .vproc_mem_we_o     (we),
    .vproc_mem_be_o     (be),
    .vproc_mem_wdata_o  (wdata),
    .vproc_mem_rvalid_i (rvalid),
    .vproc_mem_err_i    (err),
    .vproc_mem_rdata_i  (rdata),
    .timer_irq          (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit        en, per, ie;
    bit [7:0]  psc;
    bit [31:0] cmp, cnt;
    bit [7:0]  pre;
    bit        exp, irq;
  } chm_t;

  typedef struct {
    bit        err;
    bit        rd;
    bit [31:0] data;
    bit        fx;
    bit        fx_err;
    bit [31:0] fx_val;
    string     tag;
  } exp_t;

  chm_t      m [NT];
  exp_t      sb [$];
  bit        fx_on  = 1'b0;
  bit        fx_err = 1'b0;
  bit [31:0] fx_val = '0;
  string     fx_tag = "";

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic bit [31:0] merge(bit [31:0] o, bit [31:0] d,
                                      bit [3:0] b);
    bit [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit [31:0] mreg(int c, int r);
    case (r)
      0:       return {16'd0, m[c].psc, 5'd0, m[c].ie, m[c].per, m[c].en};
      1:       return m[c].cmp;
      2:       return m[c].cnt;
      default: return {31'd0, m[c].exp};
    endcase
  endfunction

  function automatic bit [NT-1:0] mirq();
    bit [NT-1:0] v;
    for (int k = 0; k < NT; k++) v[k] = m[k].irq;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) m[k] = '{default: '0};
  endtask

  task automatic model_step();
    exp_t      e;
    longint    a;
    bit        ok;
    int        c, r;
    bit [31:0] oc, om, w;
    bit        set, tick, nirq, wr;
    a  = longint'(addr) - longint'(BASE);
    ok = (a >= 0) && (a < 4 * NT);
    c  = ok ? int'(a / 4) : 0;
    r  = ok ? int'(a % 4) : 0;
    if (req) begin
      e.err    = !ok || (we && r == 2);
      e.rd     = !we;
      e.data   = (e.err || we) ? 32'd0 : mreg(c, r);
      e.fx     = fx_on;
      e.fx_err = fx_err;
      e.fx_val = fx_val;
      e.tag    = fx_tag;
      sb.push_back(e);
    end
    for (int k = 0; k < NT; k++) begin
      oc   = mreg(k, 0);
      om   = mreg(k, 1);
      nirq = m[k].exp && m[k].ie;
      set  = 0;
      tick = 0;
      if (m[k].en && m[k].cmp != 0) begin
        if (m[k].pre >= m[k].psc) begin
          m[k].pre = 0;
          tick     = 1;
        end else begin
          m[k].pre++;
        end
      end
      if (tick) begin
        if (m[k].cnt + 32'd1 == m[k].cmp) begin
          set = 1;
          if (m[k].per) m[k].cnt = 0;
          else begin
            m[k].cnt = m[k].cmp;
            m[k].en  = 0;
          end
        end else begin
          m[k].cnt = m[k].cnt + 32'd1;
        end
      end
      if (set) m[k].exp = 1;
      wr = req && we && ok && (r != 2) && (be != 0) && (k == c);
      if (wr && r == 0) begin
        w        = merge(oc, wdata, be);
        m[k].en  = w[0];
        m[k].per = w[1];
        m[k].ie  = w[2];
        m[k].psc = w[15:8];
      end
      if (wr && r == 3 && be[0] && wdata[0] && !set) m[k].exp = 0;
      if (wr && r == 1) begin
        m[k].cmp = merge(om, wdata, be);
        m[k].cnt = 0;
        m[k].pre = 0;
        m[k].exp = 0;
      end
      m[k].irq = nirq;
    end
  endtask

  always @(posedge clk) if (!rst) model_step();

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    chk("irq", 32'(irq), 32'(mirq()));
    if (rvalid) begin
      if (sb.size() == 0) begin
        chk("spurious_rvalid", 32'(rvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", 32'(err), 32'(e.err));
        if (e.rd || e.err) chk("resp_rdata", rdata, e.data);
        if (e.fx) begin
          chk({e.tag, "_err"}, 32'(err), 32'(e.fx_err));
          chk(e.tag, rdata, e.fx_val);
        end
      end
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
      chk("missing_rvalid", 32'(rvalid), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit [31:0] ra(int c, int r);
    return BASE + 32'(4 * c + r);
  endfunction

  task automatic bus(bit w, bit [31:0] a, bit [3:0] b, bit [31:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    be    = '0;
    fx_on = 1'b0;
  endtask

  task automatic bus_fx(string t, bit w, bit [31:0] a, bit [3:0] b,
                        bit [31:0] d, bit fe, bit [31:0] fv);
    fx_on  = 1'b1;
    fx_err = fe;
    fx_val = fv;
    fx_tag = t;
    bus(w, a, b, d);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int        c, r;
    bit        w;
    bit [3:0]  b;
    bit [31:0] a, d;
    model_reset();
    #1 rst = 1'b1;
    #10;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // one-shot ch0, CMP=10
    bus(1, ra(0, 1), 4'hF, 32'd10);
    bus(1, ra(0, 0), 4'hF, 32'h1);
    for (int i = 1; i <= 12; i++)
      bus_fx("oneshot_status", 0, ra(0, 3), 0, 0, 0, 32'(i >= 11));
    bus_fx("oneshot_count", 0, ra(0, 2), 0, 0, 0, 32'd10);
    bus_fx("oneshot_ctrl", 0, ra(0, 0), 0, 0, 0, 32'd0);

    // periodic ch1, PSC=7, CMP=3
    bus(1, ra(1, 0), 4'hF, 32'h0703);
    bus(1, ra(1, 1), 4'hF, 32'd3);
    for (int i = 1; i <= 26; i++)
      bus_fx("periodic_st1", 0, ra(1, 3), 0, 0, 0, 32'(i >= 25));
    bus(1, ra(1, 3), 4'h1, 32'h1);
    for (int i = 1; i <= 23; i++)
      bus_fx("periodic_st2", 0, ra(1, 3), 0, 0, 0, 32'(i >= 22));

    // byte enables
    bus_fx("be0_write", 1, ra(0, 1), 4'h0, 32'hFF, 0, 0);
    bus_fx("be0_cmp", 0, ra(0, 1), 0, 0, 0, 32'd10);
    bus(1, ra(3, 1), 4'b0010, 32'h1234_AB56);
    bus_fx("be_partial", 0, ra(3, 1), 0, 0, 0, 32'h0000_AB00);
    bus_fx("ctrl_mask", 1, ra(3, 0), 4'hF, 32'hFFFF_0AF8, 0, 0);
    bus_fx("ctrl_mask_rd", 0, ra(3, 0), 0, 0, 0, 32'h0000_0A00);

    // irq ch2
    bus(1, ra(2, 0), 4'hF, 32'h5);
    bus(1, ra(2, 1), 4'hF, 32'd5);
    idle(5);
    chk("irq_lag", 32'(irq), 32'd0);
    idle(1);
    chk("irq_rise", 32'(irq), 32'h4);
    bus(1, ra(2, 3), 4'h1, 32'h1);
    chk("irq_hold", 32'(irq), 32'h4);
    idle(1);
    chk("irq_w1c", 32'(irq), 32'd0);

    // errors
    bus_fx("count_wr", 1, ra(0, 2), 4'hF, 32'h55, 1, 0);
    bus_fx("past_map", 0, BASE + 32'(4 * NT), 0, 0, 1, 0);
    bus_fx("below_map", 0, BASE - 32'd1, 0, 0, 1, 0);
    bus_fx("count_kept", 0, ra(0, 2), 0, 0, 0, 32'd10);

    // coincidences on ch3
    bus(1, ra(3, 0), 4'hF, 32'h1);
    bus(1, ra(3, 1), 4'hF, 32'd4);
    idle(3);
    bus(1, ra(3, 3), 4'h1, 32'h1);
    bus_fx("set_beats_w1c", 0, ra(3, 3), 0, 0, 0, 32'd1);
    bus(1, ra(3, 3), 4'h1, 32'h1);
    bus(1, ra(3, 0), 4'hF, 32'h3);
    bus(1, ra(3, 1), 4'hF, 32'd4);
    idle(3);
    bus(1, ra(3, 1), 4'hF, 32'd4);
    bus_fx("cmpwr_count", 0, ra(3, 2), 0, 0, 0, 32'd0);
    bus_fx("cmpwr_status", 0, ra(3, 3), 0, 0, 0, 32'd0);
    bus(1, ra(3, 0), 4'hF, 32'h0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        c = $urandom_range(0, NT - 1);
        r = $urandom_range(0, 3);
        a = ra(c, r);
        w = 1'($urandom_range(0, 1));
        b = 4'($urandom);
        d = $urandom;
        if ($urandom_range(0, 9) == 0)
          a = BASE + 32'($urandom_range(0, 4 * NT + 3)) - 32'd2;
        if (r == 0) d[15:10] = '0;
        if (r == 1 && $urandom_range(0, 3) != 0)
          d = 32'($urandom_range(0, 12));
        if ($urandom_range(0, 2) == 0) b = 4'hF;
        bus(w, a, b, d);
      end
    end
    idle(2);

    // reset mid-count and mid-transaction
    bus(1, ra(0, 1), 4'hF, 32'd50);
    bus(1, ra(0, 0), 4'hF, 32'h5);
    idle(10);
    bus(0, ra(0, 0), 0, 0);
    rst = 1'b1;
    model_reset();
    sb.delete();
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    idle(3);
    rst = 1'b0;
    bus_fx("post_rst_ctrl", 0, ra(0, 0), 0, 0, 0, 32'd0);
    for (int k = 0; k < NT; k++)
      for (int j = 0; j < 4; j++)
        bus_fx("post_rst_reg", 0, ra(k, j), 0, 0, 0, 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    idle(2);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
